// File: rtl/pipeline_stage_register.sv
// ============================================================================
// Module   : pipeline_stage_register
// Brief    : Valid/ready pipeline register with optional two-entry skid buffer
//            (PIPE_STAGE_SKID_EN) that registers the backpressure path.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_stage_register #(
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY
);

    logic              in_fire;
    logic              out_fire;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;

`ifdef PIPE_STAGE_SKID_EN
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              in_ready_q;
    logic              in_ready_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    assign in_fire   = IN_VALID && in_ready_q;
    assign out_fire  = (state_q != ST_EMPTY) && OUT_READY;
    assign IN_READY  = in_ready_q;
    assign OUT_VALID = (state_q != ST_EMPTY);
    assign OUT_DATA  = main_q;
    assign OCCUPANCY = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            // Squash clears only valid state; payload registers keep their values.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = IN_DATA;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = IN_DATA;
                    end else if (in_fire) begin
                        state_d = ST_TWO;
                        skid_d  = IN_DATA;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Ready is a flop copy of the next state, so OUT_READY never reaches IN_READY combinationally.
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= RESET_DATA;
            skid_q     <= RESET_DATA;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end
`else
    logic valid_q;
    logic valid_d;
    logic in_ready_w;

    assign in_ready_w = RESET_N && (!valid_q || OUT_READY);
    assign in_fire    = IN_VALID && in_ready_w;
    assign out_fire   = valid_q && OUT_READY;
    assign IN_READY   = in_ready_w;
    assign OUT_VALID  = valid_q;
    assign OUT_DATA   = main_q;
    assign OCCUPANCY  = {1'b0, valid_q};

    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (FLUSH) begin
            valid_d = 1'b0;
        end else if (in_fire) begin
            valid_d = 1'b1;
            main_d  = IN_DATA;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q <= 1'b0;
            main_q  <= RESET_DATA;
        end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stage_register.sv
// ============================================================================
// Module   : tb_pipeline_stage_register
// Brief    : Directed vector table plus hand sequences and random scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_stage_register;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] IN_DATA = 32'h0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] OUT_DATA;
    logic [1:0]  OCCUPANCY;

    pipeline_stage_register #(.DATA_W(32), .RESET_DATA(RST_VAL)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OCCUPANCY(OCCUPANCY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        flush;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_occ;
        logic        exp_ready;
    } vec_t;

    vec_t        vecs [14];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic [31:0] d,
                               input logic [1:0] o, input logic r);
        chk({tag, ".out_valid"}, {31'd0, OUT_VALID}, {31'd0, v});
        chk({tag, ".out_data"},  OUT_DATA, d);
        chk({tag, ".occupancy"}, {30'd0, OCCUPANCY}, {30'd0, o});
        chk({tag, ".in_ready"},  {31'd0, IN_READY}, {31'd0, r});
    endtask

    // Sample fires mid-cycle and keep a reference queue of accepted payloads.
    task automatic sb_cycle(input string tag);
        if (OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                chk({tag, ".unexpected_out"}, OUT_DATA, 32'hFFFF_FFFF);
            end else begin
                chk({tag, ".order"}, OUT_DATA, sb.pop_front());
            end
        end
        if (IN_VALID && IN_READY) sb.push_back(IN_DATA);
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 32'(i + 1), 1'b1, 1'b0, 1'b1, 32'(i + 1), 2'd1, 1'b1};
        vecs[8]  = '{1'b1, 32'd9,  1'b0, 1'b1, 1'b0, 32'd8,  2'd0, 1'b1};
        vecs[9]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 32'd8,  2'd0, 1'b1};
        vecs[10] = '{1'b1, 32'd10, 1'b0, 1'b0, 1'b1, 32'd10, 2'd1, SKID};
        vecs[11] = '{1'b1, 32'd11, 1'b0, 1'b0, 1'b1, 32'd10, SKID ? 2'd2 : 2'd1, 1'b0};
        vecs[12] = '{1'b1, 32'd12, 1'b1, 1'b0, 1'b1, SKID ? 32'd11 : 32'd12, 2'd1, 1'b1};
        vecs[13] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b0, SKID ? 32'd11 : 32'd12, 2'd0, 1'b1};

        // Asynchronous reset between edges, checked before any clock edge.
        #2 RESET_N = 1'b0;
        #1 check_state("reset", 1'b0, RST_VAL, 2'd0, SKID);
        #19 RESET_N = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            IN_VALID  = vecs[i].in_valid;
            IN_DATA   = vecs[i].in_data;
            OUT_READY = vecs[i].out_ready;
            FLUSH     = vecs[i].flush;
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                        vecs[i].exp_occ, vecs[i].exp_ready);
        end
        FLUSH = 1'b0;
        IN_VALID = 1'b0;

`ifdef PIPE_STAGE_SKID_EN
        IN_VALID = 1'b1; IN_DATA = 32'd5; OUT_READY = 1'b0;
        tick(); check_state("skid_one", 1'b1, 32'd5, 2'd1, 1'b1);
        IN_DATA = 32'd6;
        tick(); check_state("skid_two", 1'b1, 32'd5, 2'd2, 1'b0);
        IN_DATA = 32'd7;
        tick(); check_state("skid_hold", 1'b1, 32'd5, 2'd2, 1'b0);
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        #1 chk("skid_ready_registered", {31'd0, IN_READY}, 32'd0);
        tick(); check_state("skid_drain6", 1'b1, 32'd6, 2'd1, 1'b1);
        tick(); check_state("skid_empty", 1'b0, 32'd6, 2'd0, 1'b1);

        IN_VALID = 1'b1; IN_DATA = 32'd5; OUT_READY = 1'b0;
        tick();
        IN_DATA = 32'd6;
        tick(); chk("flush_pre_occ", {30'd0, OCCUPANCY}, 32'd2);
        FLUSH = 1'b1; IN_DATA = 32'd9;
        tick(); check_state("flush_two", 1'b0, 32'd5, 2'd0, 1'b1);
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        tick(); check_state("flush_after", 1'b0, 32'd5, 2'd0, 1'b1);

        IN_VALID = 1'b1; IN_DATA = 32'd5; OUT_READY = 1'b0;
        tick();
        IN_DATA = 32'd6;
        tick();
        IN_VALID = 1'b0;
        #2 RESET_N = 1'b0;
        #1 check_state("midreset", 1'b0, RST_VAL, 2'd0, 1'b1);
`else
        IN_VALID = 1'b1; IN_DATA = 32'h21; OUT_READY = 1'b1;
        tick(); check_state("ns_load", 1'b1, 32'h21, 2'd1, 1'b1);
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        #1 chk("ns_ready_low", {31'd0, IN_READY}, 32'd0);
        OUT_READY = 1'b1;
        #1 chk("ns_ready_high", {31'd0, IN_READY}, 32'd1);
        IN_VALID = 1'b1; IN_DATA = 32'h22;
        tick(); check_state("ns_replace", 1'b1, 32'h22, 2'd1, 1'b1);
        IN_VALID = 1'b0;
        tick(); check_state("ns_empty", 1'b0, 32'h22, 2'd0, 1'b1);

        IN_VALID = 1'b1; IN_DATA = 32'h23; OUT_READY = 1'b0;
        tick();
        IN_VALID = 1'b0;
        #2 RESET_N = 1'b0;
        #1 check_state("midreset", 1'b0, RST_VAL, 2'd0, 1'b0);
`endif
        #1 RESET_N = 1'b1;
        tick();

        for (int c = 0; c < 1000; c++) begin
            IN_VALID  = 1'($urandom_range(0, 1));
            IN_DATA   = $urandom;
            OUT_READY = 1'($urandom_range(0, 1));
            #3;
            chk("rand_occ", {30'd0, OCCUPANCY}, 32'(sb.size()));
            chk("rand_valid", {31'd0, OUT_VALID}, {31'd0, (sb.size() != 0)});
`ifdef PIPE_STAGE_SKID_EN
            begin
                logic r;
                r = IN_READY;
                OUT_READY = ~OUT_READY;
                #1 chk("rand_ready_no_comb", {31'd0, IN_READY}, {31'd0, r});
                OUT_READY = ~OUT_READY;
                #1;
            end
`endif
            sb_cycle("rand");
            tick();
        end

        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #3 sb_cycle("drain");
            tick();
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_occ", {30'd0, OCCUPANCY}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
